// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, line levels and the
// parity helper that the receiver will also use.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SYNC,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   // Data is passed zero-extended to the widest legal frame; the extra zeros
   // do not change the XOR reduction.
   function automatic logic parity_bit(input logic [8:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: LSB-first start/data/[parity]/stop frame, one bit per baud tick.
// Define UART_TX_PARITY_EN to compile in the parity bit.
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 baud_tick,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 tx_busy,
   output logic                 tx_done
);

   localparam int IDX_W = $clog2(DATA_BITS);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
   localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

   if (DATA_BITS < 5 || DATA_BITS > 9 || !(STOP_BITS == 1 || STOP_BITS == 2) ||
       !(PARITY_ODD == 0 || PARITY_ODD == 1)) begin : g_param_check
      $error("uart_tx: illegal parameter value");
   end

   state_t               state, state_nx;
   logic [DATA_BITS-1:0] shreg, shreg_nx;
   logic [IDX_W-1:0]     bit_idx, bit_idx_nx;
   logic                 stop_cnt, stop_cnt_nx;
   logic                 tx_nx;
   logic                 done_nx;
   logic                 hs;
`ifdef UART_TX_PARITY_EN
   logic                 par, par_nx;
`endif

   always_comb begin
      hs          = tx_valid && tx_ready;
      state_nx    = state;
      shreg_nx    = shreg;
      bit_idx_nx  = bit_idx;
      stop_cnt_nx = stop_cnt;
      tx_nx       = tx;
      done_nx     = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_nx      = par;
`endif
      case (state)
         IDLE: begin
            tx_nx = LINE_IDLE;
            if (hs) begin
               state_nx    = SYNC;
               shreg_nx    = tx_data;
               bit_idx_nx  = '0;
               stop_cnt_nx = 1'b0;
`ifdef UART_TX_PARITY_EN
               par_nx      = parity_bit(9'(tx_data), 1'(PARITY_ODD));
`endif
            end
         end
         // SYNC holds the line idle until the next tick so the start bit is tick-aligned.
         SYNC: begin
            if (baud_tick) begin
               state_nx = START;
               tx_nx    = START_BIT;
            end
         end
         START: begin
            if (baud_tick) begin
               state_nx   = DATA;
               tx_nx      = shreg[0];
               shreg_nx   = shreg >> 1;
               bit_idx_nx = '0;
            end
         end
         DATA: begin
            if (baud_tick) begin
               if (bit_idx != LAST_IDX) begin
                  tx_nx      = shreg[0];
                  shreg_nx   = shreg >> 1;
                  bit_idx_nx = bit_idx + IDX_W'(1);
               end else begin
`ifdef UART_TX_PARITY_EN
                  state_nx = PARITY;
                  tx_nx    = par;
`else
                  state_nx    = STOP;
                  tx_nx       = STOP_BIT;
                  stop_cnt_nx = 1'b0;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (baud_tick) begin
               state_nx    = STOP;
               tx_nx       = STOP_BIT;
               stop_cnt_nx = 1'b0;
            end
         end
`endif
         STOP: begin
            tx_nx = STOP_BIT;
            if (baud_tick) begin
               if (stop_cnt == LAST_STOP) begin
                  state_nx = IDLE;
                  done_nx  = 1'b1;
               end else begin
                  stop_cnt_nx = stop_cnt + 1'b1;
               end
            end
         end
         default: begin
            state_nx = IDLE;
            tx_nx    = LINE_IDLE;
         end
      endcase
   end

   // tx_ready stays low through the tx_done cycle and rises one cycle later.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         tx       <= LINE_IDLE;
         tx_ready <= 1'b1;
         tx_busy  <= 1'b0;
         tx_done  <= 1'b0;
         shreg    <= '0;
         bit_idx  <= '0;
         stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par      <= 1'b0;
`endif
      end else begin
         state    <= state_nx;
         tx       <= tx_nx;
         tx_ready <= (state == IDLE) && (state_nx == IDLE);
         tx_busy  <= (state_nx != IDLE);
         tx_done  <= done_nx;
         shreg    <= shreg_nx;
         bit_idx  <= bit_idx_nx;
         stop_cnt <= stop_cnt_nx;
`ifdef UART_TX_PARITY_EN
         par      <= par_nx;
`endif
      end
   end

endmodule
